// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates stage stall requests, turns MEM exceptions into a one-cycle
// flush with redirect PC, and adds a stall watchdog plus saturating perf counters.
module pipe_ctrl #(
    parameter logic [31:0] EXC_BASE    = 32'h0000_0000,
    parameter logic [31:0] WDOG_VECTOR = 32'h0000_0060,
    parameter logic [15:0] WDOG_LIMIT  = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        perf_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdog_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    state_e      state_q, state_d;
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_pend_q, wdog_pend_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic [15:0] wdog_run;

    // Priority: exception > pending watchdog > mem > ex > id > if.
    always_comb begin
        stall        = 6'b000000;
        flush        = 1'b0;
        new_pc       = 32'h0;
        wdog_timeout = 1'b0;
        if (!rst) begin
            if (excepttype_i != 32'h0) begin
                flush = 1'b1;
                case (excepttype_i)
                    32'h0000_0001: new_pc = EXC_BASE + 32'h20;
                    32'h0000_000e: new_pc = cp0_epc_i;
                    default:       new_pc = EXC_BASE + 32'h40;
                endcase
            end else if (wdog_pend_q) begin
                flush        = 1'b1;
                new_pc       = WDOG_VECTOR;
                wdog_timeout = 1'b1;
            end else if (stallreq_from_mem) begin
                stall = 6'b011111;
            end else if (stallreq_from_ex) begin
                stall = 6'b001111;
            end else if (stallreq_from_id) begin
                stall = 6'b000111;
            end else if (stallreq_from_if) begin
                stall = 6'b000011;
            end
        end
    end

    // The run length only carries over if the previous cycle was also a stall.
    assign wdog_run = (state_q == StStall) ? wdog_cnt_q : 16'h0;

    always_comb begin
        state_d        = StRun;
        wdog_cnt_d     = 16'h0;
        wdog_pend_d    = 1'b0;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (rst) begin
            stall_cycles_d = 32'h0;
            flush_count_d  = 16'h0;
        end else begin
            if (flush) begin
                state_d = StFlush;
            end else if (stall[0]) begin
                state_d = StStall;
            end

            if (stall[0]) begin
                if ((WDOG_LIMIT != 16'd0) && (wdog_run == WDOG_LIMIT - 16'd1)) begin
                    wdog_pend_d = 1'b1;
                end else begin
                    wdog_cnt_d = wdog_run + 16'd1;
                end
            end

            if (perf_clr) begin
                stall_cycles_d = 32'h0;
                flush_count_d  = 16'h0;
            end else begin
                if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                    stall_cycles_d = stall_cycles_q + 32'd1;
                end
                if (flush && (flush_count_q != 16'hFFFF)) begin
                    flush_count_d = flush_count_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q        <= state_d;
        wdog_cnt_q     <= wdog_cnt_d;
        wdog_pend_q    <= wdog_pend_d;
        stall_cycles_q <= stall_cycles_d;
        flush_count_q  <= flush_count_d;
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage core.
- Arbitrates stall requests from the IF, ID, EX and MEM stages into the 6-bit stall vector. Converts an exception reported at MEM into a one-cycle flush plus a redirect PC.
- This block drives the stall/flush inputs of every pipeline register: pc_reg, if_id, id_ex, ex_mem, mem_wb.
- Adds a stall watchdog that forces a recovery flush, and saturating stall/flush performance counters.

Parameters:
- EXC_BASE, 32'h0000_0000, base of the exception vectors.
- WDOG_VECTOR, 32'h0000_0060, redirect PC used on a watchdog flush.
- WDOG_LIMIT, 16'd1024, consecutive stall cycles that trigger a watchdog flush; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_from_if  in  1  IF stage stall request
- stallreq_from_id  in  1  ID stage stall request
- stallreq_from_ex  in  1  EX stage stall request
- stallreq_from_mem  in  1  MEM stage stall request
- excepttype_i  in  32  final exception type from MEM; 0 = none
- cp0_epc_i  in  32  EPC from CP0, used for eret
- perf_clr  in  1  synchronous clear of the performance counters
- stall  out  6  [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = hold
- flush  out  1  flush all pipeline registers this cycle
- new_pc  out  32  redirect PC; valid only while flush=1, otherwise 0
- wdog_timeout  out  1  one-cycle pulse, coincident with a watchdog flush
- stall_cycles  out  32  saturating count of cycles with stall[0]=1
- flush_count  out  16  saturating count of cycles with flush=1

Behaviour:
- stall, flush and new_pc are combinational from the current inputs and the registered state, with zero latency. While rst=1 they are forced to 0.
- Reset values: wdog_cnt, wdog_pend, wdog_timeout, stall_cycles and flush_count all 0. FSM state = RUN.
- Priority, highest first:
  1. rst
  2. external exception (excepttype_i != 0)
  3. wdog_pend
  4. stallreq_from_mem
  5. stallreq_from_ex
  6. stallreq_from_id
  7. stallreq_from_if
  8. none
- Flush cycle: flush=1 and stall=6'b000000. All stall requests are ignored that cycle.
- Stall encoding:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
- new_pc mapping for an external exception:
  - 32'h1 (interrupt) -> EXC_BASE+32'h20
  - 32'he (eret) -> cp0_epc_i
  - any other nonzero value -> EXC_BASE+32'h40
- Watchdog flush: new_pc=WDOG_VECTOR and wdog_timeout=1 in that same cycle.
- FSM, registered, states RUN, STALL, FLUSH; the state records the previous cycle's outcome:
  - flush this cycle -> next state FLUSH
  - else stall[0]=1 this cycle -> next state STALL
  - else -> next state RUN
  - FLUSH lasts exactly one cycle unless another flush is raised in the following cycle.
- Watchdog counter wdog_cnt, 16 bits:
  - increments each cycle with stall[0]=1 and flush=0
  - clears on any cycle with stall[0]=0 or flush=1
- Watchdog trigger: if WDOG_LIMIT!=0 and wdog_cnt==WDOG_LIMIT-1 in a stalled cycle, wdog_pend is set for the next cycle and wdog_cnt clears.
- wdog_pend:
  - produces exactly one flush cycle, then clears
  - if an external exception arrives in the same cycle, the external flush wins, wdog_pend clears and no wdog_timeout is emitted
- stall_cycles: +1 per cycle with stall[0]=1; holds at 32'hFFFF_FFFF.
- flush_count: +1 per cycle with flush=1; holds at 16'hFFFF.
- perf_clr:
  - zeroes both performance counters next cycle
  - has priority over an increment in the same cycle
  - does not affect the watchdog
- Reset mid-stall or mid-pending: everything returns to reset values next cycle; a pending watchdog flush is dropped.
- Multiple simultaneous stall requests: only the highest-priority pattern is driven; no OR-merging of patterns.

Test Plan:
- Stall encoding: apply id=1 then ex=1 then mem=1, each held 3 cycles -> stall = 000111, 001111, 011111; stall_cycles=9; flush stays 0.
- Exception overrides stall: mem stall plus excepttype_i=32'h8 in the same cycle, EXC_BASE=0 -> stall=0, flush=1, new_pc=32'h40; next cycle (excepttype 0, mem still requesting) -> stall=011111; flush_count=1.
- Interrupt and eret: excepttype_i=1 -> new_pc=32'h20. Then excepttype_i=32'he with cp0_epc_i=32'h1234 -> new_pc=32'h1234. Each case gives one flush cycle.
- Watchdog:
  - WDOG_LIMIT=4, hold stallreq_from_if=1 for 6 cycles -> cycles 0-3 stall=000011; cycle 4 flush=1, new_pc=32'h60, wdog_timeout=1; cycle 5 stall=000011 with wdog_cnt restarted at 0.
  - Repeat with excepttype_i=1 in cycle 4 -> new_pc=32'h20, wdog_timeout=0.
- Saturation and clear: preload stall_cycles to 32'hFFFF_FFFE, stall 3 cycles -> reads 32'hFFFF_FFFF. Assert perf_clr together with a stall -> 0 next cycle.
- Mid-operation reset: rst=1 while wdog_pend=1 -> next cycle all outputs 0, no flush issued after rst is released.
